// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline front end.
//   ADDR_W / INSTR_W : address and instruction widths
//   PC_STEP          : byte increment between sequential fetches
//   fetch_state_t    : fetch control state (HOLD, RUN)
//   fetch_entry_t    : {pc, instr} pair buffered for decode
package pipeline_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic [0:0] {
    HOLD = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
//   imem_req_valid/ready/addr : read request channel (fetch -> memory)
//   imem_rsp_valid/data       : in-order read response (memory -> fetch)
//   if_valid/ready/pc/instr   : fetched instruction stream (fetch -> decode)
// Modports: master = fetch stage side, slave = memory/decode side.
interface fetch_stage_if
  import pipeline_pkg::*;
();

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               if_valid;
  logic               if_ready;
  logic [ADDR_W-1:0]  if_pc;
  logic [INSTR_W-1:0] if_instr;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used for the instruction buffer and the
// request-address queue.
//   clk, reset_n : clock, async active-low reset
//   push/push_data, pop : enqueue / dequeue strobes (no push when full unless popping)
//   flush        : empties the FIFO; a push in the same cycle lands as the sole entry
//   head         : oldest entry, forced to zero while empty
//   count        : current occupancy (0..DEPTH)
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_q, wr_q, wr_idx;
  logic [CntW-1:0]  cnt_q;

  assign wr_idx = flush ? '0 : wr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= PtrW'(push);
      cnt_q <= CntW'(push);
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= push_data;
  end

  // Gate the head so stale storage never shows up on the outputs.
  assign head  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues in-order memory reads under
// a credit limit and buffers {pc, instr} pairs for decode.
//   clk, reset_n      : clock, async active-low reset
//   pcSelect          : hold fetch and load PC from startAddress
//   startAddress      : PC load value (bits [1:0] ignored)
//   redirect_valid    : one-cycle branch redirect (honoured in RUN only)
//   redirect_target   : redirect PC (bits [1:0] ignored)
//   bus               : fetch_stage_if.master (imem request/response, decode stream)
// Optional: define FETCH_PERF_EN to add perf_fetch_count / perf_drop_count.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pcSelect,
  input  logic [ADDR_W-1:0] startAddress,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  fetch_stage_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_count,
  output logic [31:0]       perf_drop_count
`endif
);

  localparam int unsigned     CntW     = $clog2(DEPTH + 1);
  localparam logic [CntW:0]   DepthLim = (CntW + 1)'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, req_addr, start_pc, redir_pc, aq_head;
  logic [CntW-1:0]   out_q, out_d, drop_q, drop_d, fifo_count, aq_count;
  fetch_entry_t      head, push_entry;
  logic running, flush, redir, pop, credit, req_valid, fire, rsp, keep, discard;

  assign start_pc = align_word(startAddress);
  assign redir_pc = align_word(redirect_target);
  assign running  = (state_q == RUN);
  assign flush    = running & (pcSelect | redirect_valid);
  assign redir    = running & ~pcSelect & redirect_valid;
  assign pop      = bus.if_valid & bus.if_ready & ~flush;

  // A slot freed by this cycle's pop is reusable immediately, which is what
  // sustains one fetch per cycle at short memory latency.
  assign credit    = ({1'b0, fifo_count} + {1'b0, out_q} - (CntW + 1)'(pop)) < DepthLim;
  assign req_valid = running & ~pcSelect & credit;
  // A request issued in the redirect cycle already targets the new stream.
  assign req_addr  = redir ? redir_pc : pc_q;
  assign fire      = req_valid & bus.imem_req_ready;
  assign rsp       = bus.imem_rsp_valid & (out_q != '0);
  assign keep      = rsp & (drop_q == '0) & ~flush & (aq_count != '0);
  assign discard   = rsp & ~keep;

  assign push_entry = '{pc: aq_head, instr: bus.imem_rsp_data};

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_addr;
  assign bus.if_valid       = (fifo_count != '0);
  assign bus.if_pc          = head.pc;
  assign bus.if_instr       = head.instr;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q + CntW'(fire) - CntW'(rsp);
    drop_d  = drop_q;
    case (state_q)
      HOLD: begin
        if (pcSelect) pc_d = start_pc;
        else          state_d = RUN;
      end
      RUN: begin
        if (pcSelect) begin
          pc_d    = start_pc;
          state_d = HOLD;
        end else if (fire) begin
          pc_d = req_addr + PC_STEP;
        end else if (redir) begin
          pc_d = redir_pc;
        end
      end
      default: state_d = HOLD;
    endcase
    // Everything still in flight at a flush belongs to the abandoned stream.
    if (flush)                     drop_d = out_q - CntW'(rsp);
    else if (rsp && drop_q != '0)  drop_d = drop_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLD;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W)
  ) u_addr_q (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fire),
    .push_data (req_addr),
    .pop       (keep),
    .flush     (flush),
    .head      (aq_head),
    .count     (aq_count)
  );

  fetch_fifo #(
    .DEPTH ($bits(fetch_entry_t) > 0 ? DEPTH : DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_instr_q (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (fifo_count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_count <= '0;
      perf_drop_count  <= '0;
    end else begin
      if (bus.if_valid && bus.if_ready) perf_fetch_count <= perf_fetch_count + 32'd1;
      if (discard)                      perf_drop_count  <= perf_drop_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of `pipeline`. Owns the program counter, issues in-order instruction-memory reads, and buffers returned instructions in a small FIFO. Presents `{pc, instr}` pairs to the decode stage over a valid/ready handshake. Accepts a start-address load (`pcSelect`/`startAddress`) and branch redirects from downstream.

## Interface
- `DEPTH`, 2: instruction FIFO depth; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pcSelect` in 1: while high, PC ← `startAddress` each cycle and fetch is held.
- `startAddress` in 32: load value for PC.
- `redirect_valid` in 1: one-cycle branch/jump redirect from downstream.
- `redirect_target` in 32: new PC on redirect.
- `imem_req_valid` out 1: read request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_rsp_valid` in 1: read data valid; responses return in order, ≥1 cycle after acceptance.
- `imem_rsp_data` in 32: instruction word.
- `if_valid` out 1: FIFO head valid to decode.
- `if_ready` in 1: decode accepts head.
- `if_pc` out 32, `if_instr` out 32: head entry.

## Operation
- States: HOLD, RUN. Reset → HOLD.
- HOLD: `imem_req_valid`=0. PC ← `startAddress` every cycle `pcSelect`=1. Go to RUN on the first edge where `pcSelect`=0.
- RUN: `pcSelect`=1 → flush (below), PC ← `startAddress`, go to HOLD.
- Credit rule: `imem_req_valid` = RUN & (fifo_count + outstanding < DEPTH). Outstanding ≤ DEPTH, so the FIFO never overflows.
- Request fire (valid & ready): PC ← PC + 4 (32-bit wrap, FFFF_FFFC → 0000_0000); outstanding++.
- Response: outstanding--. If drop_count > 0, discard and decrement drop_count. Otherwise push `{pc_of_request, data}`; request PCs are held in a DEPTH-entry address queue.
- Redirect (`redirect_valid`=1 in RUN): FIFO and address queue emptied. drop_count ← outstanding minus any response arriving that cycle. PC ← `redirect_target`. A request firing the same cycle is issued to `redirect_target`, not the old PC.
- Priority: reset > `pcSelect` > redirect > normal advance.
- Simultaneous push and pop on a full FIFO: allowed, count unchanged.
- `redirect_target`/`startAddress` bits [1:0] are ignored (forced 0).

## Timing
- Reset values: state=HOLD, PC=RESET_PC, `imem_req_valid`=0, `if_valid`=0, `if_pc`=0, `if_instr`=0, counts=0.
- `imem_req_addr` = PC register, valid combinationally in the same cycle as `imem_req_valid`.
- First request asserts one cycle after the edge that samples `pcSelect`=0.
- Response-to-`if_valid` latency: 1 cycle (registered push). FIFO head is registered.
- `if_valid` is deasserted the cycle after redirect/`pcSelect`; no stale entry is ever presented.
- Asynchronous reset mid-operation clears everything. In-flight memory responses after reset release are not tracked; the memory is reset by the same `reset_n`.
- Full throughput: one instruction per cycle when `imem_req_ready`=1, `if_ready`=1, and response latency ≤ DEPTH−1.

## Configuration
- `FETCH_PERF_EN` defined: adds output `perf_fetch_count` (32) counting FIFO pops (`if_valid & if_ready`) and output `perf_drop_count` (32) counting discarded responses. Both reset to 0 and wrap.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Structure
- `pipeline_pkg`: `ADDR_W`=32, `INSTR_W`=32, `PC_STEP`=4, `fetch_state_t` {HOLD, RUN}, `fetch_entry_t` {pc, instr}.
- One sub-module: `fetch_fifo` (parameterised DEPTH, push/pop/flush, count out), instantiated twice: instruction FIFO and request-address queue.

## Test plan
- Reset, `startAddress`=0, `pcSelect` 1→0 at 16 ns, memory ready, latency 1, decode ready → request addresses 0,4,8,C…; `if_pc`/`if_instr` pairs match memory, one per cycle.
- `if_ready`=0 for 10 cycles → exactly DEPTH requests issued, then `imem_req_valid`=0; on release, pairs resume in order with none lost.
- Redirect to 0x100 while 2 requests are outstanding → both responses dropped; next `if_pc`=0x100, then 0x104.
- `startAddress`=0xFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `pcSelect` reasserted mid-run with `startAddress`=0x40 → `if_valid`=0 next cycle; after release, first `if_pc`=0x40.
- `reset_n` pulsed low mid-stream → all outputs take reset values immediately; with `FETCH_PERF_EN`, counters read 0 and later match the pop/drop totals.
